// File: rtl/multiport_scoreboard_pkg.sv
// multiport_scoreboard_pkg: shared widths, FSM encoding and issue-record type for the scoreboard.
package multiport_scoreboard_pkg;
    localparam int SB_NREGS = 32;
    localparam int SB_NFU = 5;
    localparam int SB_NWB = 2;
    localparam int SB_RW = $clog2(SB_NREGS);
    localparam int SB_FW = $clog2(SB_NFU);
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_BR_WAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;
    typedef enum logic [1:0] {
        RUN = ST_RUN,
        BR_WAIT = ST_BR_WAIT,
        DRAIN = ST_DRAIN,
        HALTED = ST_HALTED
    } sb_state_t;
    typedef struct packed {
        logic [SB_RW-1:0] rd;
        logic [SB_RW-1:0] rs1;
        logic [SB_RW-1:0] rs2;
        logic [SB_FW-1:0] fu;
        logic rd_en;
    } sb_issue_t;
endpackage

// File: rtl/multiport_scoreboard_if.sv
// multiport_scoreboard_if: fetch, issue, writeback, branch and status signals of the scoreboard.
interface multiport_scoreboard_if
    import multiport_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int NFU = SB_NFU,
    parameter int NWB = SB_NWB
) ();
    localparam int RW = $clog2(NREGS);
    localparam int FW = $clog2(NFU);
    logic fetch_valid;
    logic [RW-1:0] fetch_rd;
    logic [RW-1:0] fetch_rs1;
    logic [RW-1:0] fetch_rs2;
    logic fetch_rd_en;
    logic fetch_rs1_en;
    logic fetch_rs2_en;
    logic [FW-1:0] fetch_fu;
    logic fetch_branch;
    logic fetch_halt_req;
    logic freeze;
    logic issue_valid;
    logic issue_ready;
    logic [RW-1:0] issue_rd;
    logic [RW-1:0] issue_rs1;
    logic [RW-1:0] issue_rs2;
    logic [FW-1:0] issue_fu;
    logic issue_rd_en;
    logic [NWB-1:0] wb_valid;
    logic [NWB*RW-1:0] wb_rd;
    logic [NWB-1:0] wb_rd_en;
    logic [NWB*FW-1:0] wb_fu;
    logic branch_resolved;
    logic branch_miss;
    logic jump;
    logic fetch_halt;
    logic halt;
    logic [NREGS-1:0] pending;
    modport master (
        output fetch_valid, fetch_rd, fetch_rs1, fetch_rs2, fetch_rd_en, fetch_rs1_en, fetch_rs2_en,
        output fetch_fu, fetch_branch, fetch_halt_req, issue_ready,
        output wb_valid, wb_rd, wb_rd_en, wb_fu, branch_resolved, branch_miss,
        input freeze, issue_valid, issue_rd, issue_rs1, issue_rs2, issue_fu, issue_rd_en,
        input jump, fetch_halt, halt, pending
    );
    modport slave (
        input fetch_valid, fetch_rd, fetch_rs1, fetch_rs2, fetch_rd_en, fetch_rs1_en, fetch_rs2_en,
        input fetch_fu, fetch_branch, fetch_halt_req, issue_ready,
        input wb_valid, wb_rd, wb_rd_en, wb_fu, branch_resolved, branch_miss,
        output freeze, issue_valid, issue_rd, issue_rs1, issue_rs2, issue_fu, issue_rd_en,
        output jump, fetch_halt, halt, pending
    );
endinterface

// File: rtl/multiport_scoreboard_reg_table.sv
// multiport_scoreboard_reg_table: pending-register bits with one set port, NWB clear ports and
// three lookups that already see this cycle's clears.
module multiport_scoreboard_reg_table
    import multiport_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int NWB = SB_NWB,
    parameter int ZERO_REG = 1,
    localparam int RW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [RW-1:0]     set_idx_i,
    input  logic [NWB-1:0]    clr_en_i,
    input  logic [NWB*RW-1:0] clr_idx_i,
    input  logic [3*RW-1:0]   lk_idx_i,
    output logic [2:0]        lk_o,
    output logic [NREGS-1:0]  pending_o
);
    logic [NREGS-1:0] pending_q, pending_d, clr_mask, set_mask, byp;
    // Set is applied after clears so a same-cycle set on a cleared register wins.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NWB; i++)
            if (clr_en_i[i]) clr_mask[clr_idx_i[i*RW +: RW]] = 1'b1;
        set_mask = (set_en_i && !(ZERO_REG != 0 && set_idx_i == '0)) ? NREGS'(1) << set_idx_i : '0;
        byp = pending_q & ~clr_mask;
        pending_d = byp | set_mask;
        lk_o = '0;
        for (int k = 0; k < 3; k++) lk_o[k] = byp[lk_idx_i[k*RW +: RW]];
    end
    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else pending_q <= pending_d;
    end
    assign pending_o = pending_q;
endmodule

// File: rtl/multiport_scoreboard.sv
// multiport_scoreboard: in-order issue scoreboard with RAW/WAW/structural stalls, multi-port
// writeback, branch blocking and halt drain.
module multiport_scoreboard
    import multiport_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int NFU = SB_NFU,
    parameter int NWB = SB_NWB,
    parameter int ZERO_REG = 1
) (
    input logic clk,
    input logic rst,
    multiport_scoreboard_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int FW = $clog2(NFU);
    logic [NFU-1:0] fu_busy_q, fu_busy_d, fu_clr, fu_byp, fu_set;
    sb_issue_t issue_q, issue_d;
    logic issue_valid_q, issue_valid_d;
    sb_state_t state_q, state_d;
    logic jump_q, jump_d;
    logic [2:0] lk;
    logic [NREGS-1:0] pend;
    logic fu_ok, hazard, accept, take, drained;
    multiport_scoreboard_reg_table #(.NREGS(NREGS), .NWB(NWB), .ZERO_REG(ZERO_REG)) u_regs (
        .clk(clk),
        .rst(rst),
        .set_en_i(take && bus.fetch_rd_en),
        .set_idx_i(bus.fetch_rd),
        .clr_en_i(bus.wb_valid & bus.wb_rd_en),
        .clr_idx_i(bus.wb_rd),
        .lk_idx_i({bus.fetch_rd, bus.fetch_rs2, bus.fetch_rs1}),
        .lk_o(lk),
        .pending_o(pend)
    );
    always_comb begin
        fu_clr = '0;
        for (int i = 0; i < NWB; i++)
            if (bus.wb_valid[i] && {1'b0, bus.wb_fu[i*FW +: FW]} < (FW+1)'(NFU))
                fu_clr[bus.wb_fu[i*FW +: FW]] = 1'b1;
    end
    assign fu_byp = fu_busy_q & ~fu_clr;
    assign fu_ok = {1'b0, bus.fetch_fu} < (FW+1)'(NFU);
    assign hazard = (bus.fetch_rs1_en && lk[0]) || (bus.fetch_rs2_en && lk[1]) ||
                    (bus.fetch_rd_en && lk[2]) || !fu_ok || fu_byp[bus.fetch_fu];
    assign accept = bus.fetch_valid && state_q == RUN && !hazard && (!issue_valid_q || bus.issue_ready);
    // A halt only changes state: it claims no register, no unit and no issue slot.
    assign take = accept && !bus.fetch_halt_req;
    assign fu_set = take ? NFU'(1) << bus.fetch_fu : '0;
    assign fu_busy_d = fu_byp | fu_set;
    assign issue_d = take ? '{rd: bus.fetch_rd, rs1: bus.fetch_rs1, rs2: bus.fetch_rs2,
                              fu: bus.fetch_fu, rd_en: bus.fetch_rd_en} : issue_q;
    assign issue_valid_d = take || (issue_valid_q && !bus.issue_ready);
    assign drained = pend == '0 && fu_busy_q == '0 && !issue_valid_q;
    assign jump_d = state_q == BR_WAIT && bus.branch_resolved && bus.branch_miss;
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && accept)
            state_d = bus.fetch_halt_req ? DRAIN : bus.fetch_branch ? BR_WAIT : RUN;
        else if (state_q == BR_WAIT && bus.branch_resolved) state_d = RUN;
        else if (state_q == DRAIN && drained) state_d = HALTED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fu_busy_q <= '0;
            issue_q <= '0;
            issue_valid_q <= 1'b0;
            state_q <= RUN;
            jump_q <= 1'b0;
        end else begin
            fu_busy_q <= fu_busy_d;
            issue_q <= issue_d;
            issue_valid_q <= issue_valid_d;
            state_q <= state_d;
            jump_q <= jump_d;
        end
    end
    assign bus.freeze = bus.fetch_valid && !accept;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_rd = issue_q.rd;
    assign bus.issue_rs1 = issue_q.rs1;
    assign bus.issue_rs2 = issue_q.rs2;
    assign bus.issue_fu = issue_q.fu;
    assign bus.issue_rd_en = issue_q.rd_en;
    assign bus.jump = jump_q;
    assign bus.fetch_halt = state_q == DRAIN || state_q == HALTED;
    assign bus.halt = state_q == HALTED;
    assign bus.pending = pend;
endmodule

// File: tb/tb_multiport_scoreboard.sv
// tb_multiport_scoreboard: directed and random stimulus against a cycle-level reference model;
// issued instructions are checked in order by a separate monitor.
module tb_multiport_scoreboard;
    localparam int NREGS = 32;
    localparam int NFU = 5;
    localparam int NWB = 2;
    localparam int RW = 5;
    localparam int FW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    multiport_scoreboard_if #(.NREGS(NREGS), .NFU(NFU), .NWB(NWB)) bus ();
    multiport_scoreboard #(.NREGS(NREGS), .NFU(NFU), .NWB(NWB), .ZERO_REG(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {int rd; int rs1; int rs2; int fu; bit rd_en;} ins_t;
    ins_t exp_q[$];
    int checks = 0;
    int failures = 0;
    bit m_pend[NREGS];
    bit m_busy[NFU];
    int m_state;
    bit m_iv, m_jump;
    logic last_freeze;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    always @(negedge clk) begin
        ins_t e;
        if (!rst && bus.issue_valid === 1'b1 && bus.issue_ready) begin
            if (exp_q.size() == 0) chk("issue_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("issue_rd", bus.issue_rd, e.rd);
                chk("issue_rs1", bus.issue_rs1, e.rs1);
                chk("issue_rs2", bus.issue_rs2, e.rs2);
                chk("issue_fu", bus.issue_fu, e.fu);
                chk("issue_rd_en", bus.issue_rd_en, e.rd_en);
            end
        end
    end
    task automatic idle();
        bus.fetch_valid = 0; bus.fetch_rd = 0; bus.fetch_rs1 = 0; bus.fetch_rs2 = 0;
        bus.fetch_rd_en = 0; bus.fetch_rs1_en = 0; bus.fetch_rs2_en = 0; bus.fetch_fu = 0;
        bus.fetch_branch = 0; bus.fetch_halt_req = 0; bus.issue_ready = 1;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_rd_en = 0; bus.wb_fu = 0;
        bus.branch_resolved = 0; bus.branch_miss = 0;
    endtask
    task automatic fetch(input int rd, input int rs1, input int rs2, input bit rde, input bit r1e,
                         input bit r2e, input int fu, input bit br, input bit hr);
        bus.fetch_valid = 1; bus.fetch_rd = RW'(rd); bus.fetch_rs1 = RW'(rs1); bus.fetch_rs2 = RW'(rs2);
        bus.fetch_rd_en = rde; bus.fetch_rs1_en = r1e; bus.fetch_rs2_en = r2e; bus.fetch_fu = FW'(fu);
        bus.fetch_branch = br; bus.fetch_halt_req = hr;
    endtask
    task automatic wb(input int p, input int rd, input bit rde, input int fu);
        bus.wb_valid[p] = 1; bus.wb_rd[p*RW +: RW] = RW'(rd);
        bus.wb_rd_en[p] = rde; bus.wb_fu[p*FW +: FW] = FW'(fu);
    endtask
    task automatic do_reset();
        rst = 1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_freeze", bus.freeze, 0);
        chk("rst_issue_valid", bus.issue_valid, 0);
        chk("rst_issue_fields", {bus.issue_rd, bus.issue_rs1, bus.issue_rs2, bus.issue_fu, bus.issue_rd_en}, 0);
        chk("rst_jump", bus.jump, 0);
        chk("rst_fetch_halt", bus.fetch_halt, 0);
        chk("rst_halt", bus.halt, 0);
        chk("rst_pending", bus.pending, 0);
        rst = 0;
        foreach (m_pend[r]) m_pend[r] = 0;
        foreach (m_busy[f]) m_busy[f] = 0;
        m_state = 0; m_iv = 0; m_jump = 0;
        exp_q.delete();
    endtask
    // Called at posedge+1 with inputs driven; checks freeze before the edge and state after it.
    task automatic step();
        bit pb[NREGS];
        bit bb[NFU];
        bit hz, acc, dr;
        int f;
        logic [NREGS-1:0] pv;
        pb = m_pend;
        bb = m_busy;
        for (int i = 0; i < NWB; i++)
            if (bus.wb_valid[i]) begin
                if (bus.wb_rd_en[i]) pb[bus.wb_rd[i*RW +: RW]] = 0;
                f = int'(bus.wb_fu[i*FW +: FW]);
                if (f < NFU) bb[f] = 0;
            end
        f = int'(bus.fetch_fu);
        hz = (bus.fetch_rs1_en && pb[bus.fetch_rs1]) || (bus.fetch_rs2_en && pb[bus.fetch_rs2]) ||
             (bus.fetch_rd_en && pb[bus.fetch_rd]);
        if (f >= NFU) hz = 1;
        else if (bb[f]) hz = 1;
        acc = bus.fetch_valid && m_state == 0 && !hz && (!m_iv || bus.issue_ready);
        dr = !m_iv;
        foreach (m_pend[r]) if (m_pend[r]) dr = 0;
        foreach (m_busy[k]) if (m_busy[k]) dr = 0;
        #1;
        last_freeze = bus.freeze;
        chk("freeze", bus.freeze, bus.fetch_valid && !acc);
        @(posedge clk);
        m_jump = m_state == 1 && bus.branch_resolved && bus.branch_miss;
        case (m_state)
            0: if (acc) m_state = bus.fetch_halt_req ? 2 : bus.fetch_branch ? 1 : 0;
            1: if (bus.branch_resolved) m_state = 0;
            2: if (dr) m_state = 3;
            default: ;
        endcase
        m_pend = pb;
        m_busy = bb;
        if (acc && !bus.fetch_halt_req) begin
            if (bus.fetch_rd_en && bus.fetch_rd != 0) m_pend[bus.fetch_rd] = 1;
            m_busy[f] = 1;
            exp_q.push_back('{rd: int'(bus.fetch_rd), rs1: int'(bus.fetch_rs1), rs2: int'(bus.fetch_rs2),
                              fu: f, rd_en: bus.fetch_rd_en});
            m_iv = 1;
        end else if (bus.issue_ready) m_iv = 0;
        #1;
        for (int r = 0; r < NREGS; r++) pv[r] = m_pend[r];
        chk("pending", bus.pending, pv);
        chk("issue_valid", bus.issue_valid, m_iv);
        chk("jump", bus.jump, m_jump);
        chk("fetch_halt", bus.fetch_halt, m_state >= 2);
        chk("halt", bus.halt, m_state == 3);
    endtask
    initial begin
        idle();
        do_reset();
        // RAW stall released by a same-cycle writeback
        fetch(5, 0, 0, 1, 0, 0, 1, 0, 0); step();
        chk("t1_pend5", bus.pending[5], 1);
        idle(); fetch(0, 5, 0, 0, 1, 0, 2, 0, 0); step();
        chk("t1_freeze_raw", last_freeze, 1);
        step();
        chk("t1_freeze_raw2", last_freeze, 1);
        wb(0, 5, 1, 1); step();
        chk("t1_accept_on_wb", last_freeze, 0);
        chk("t1_pend_clear", bus.pending, 0);
        // two writeback ports in one cycle
        idle(); wb(0, 0, 0, 2); fetch(7, 0, 0, 1, 0, 0, 0, 0, 0); step();
        idle(); fetch(9, 0, 0, 1, 0, 0, 3, 0, 0); step();
        chk("t2_pend_set", bus.pending, 32'h0000_0280);
        idle(); wb(0, 7, 1, 0); wb(1, 9, 1, 3); step();
        chk("t2_pend_clear", bus.pending, 0);
        // branch blocks issue, mispredict pulses jump
        idle(); fetch(0, 0, 0, 0, 0, 0, 4, 1, 0); step();
        idle(); fetch(10, 0, 0, 1, 0, 0, 0, 0, 0); step();
        chk("t3_freeze_br", last_freeze, 1);
        bus.branch_resolved = 1; bus.branch_miss = 1; step();
        chk("t3_freeze_res", last_freeze, 1);
        chk("t3_jump", bus.jump, 1);
        bus.branch_resolved = 0; bus.branch_miss = 0; step();
        chk("t3_accept_run", last_freeze, 0);
        chk("t3_jump_end", bus.jump, 0);
        idle(); wb(0, 10, 1, 0); wb(1, 0, 0, 4); step();
        // dispatch back-pressure
        idle(); bus.issue_ready = 0; fetch(12, 0, 0, 1, 0, 0, 1, 0, 0); step();
        idle(); bus.issue_ready = 0; fetch(13, 0, 0, 1, 0, 0, 2, 0, 0);
        repeat (4) begin
            step();
            chk("t4_freeze", last_freeze, 1);
            chk("t4_hold_rd", bus.issue_rd, 12);
            chk("t4_hold_fu", bus.issue_fu, 1);
        end
        bus.issue_ready = 1; step();
        chk("t4_accept", last_freeze, 0);
        chk("t4_next_rd", bus.issue_rd, 13);
        idle(); wb(0, 12, 1, 1); wb(1, 13, 1, 2); step();
        // random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(3) != 0)
                fetch($urandom_range(7), $urandom_range(7), $urandom_range(7), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(5),
                      $urandom_range(9) == 0, 0);
            bus.issue_ready = $urandom_range(3) != 0;
            for (int p = 0; p < NWB; p++)
                if ($urandom_range(1) != 0)
                    wb(p, $urandom_range(7), 1'($urandom_range(1)), $urandom_range(7));
            bus.branch_resolved = $urandom_range(4) == 0;
            bus.branch_miss = 1'($urandom_range(1));
            step();
        end
        for (int i = 0; i < NREGS; i++) begin
            idle(); bus.branch_resolved = 1;
            wb(0, i, 1, i % 8); wb(1, 0, 0, (i + 3) % NFU);
            step();
        end
        // halt drains behind a pending register
        idle(); fetch(3, 0, 0, 1, 0, 0, 1, 0, 0); step();
        idle(); step();
        fetch(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        chk("t6_fetch_halt", bus.fetch_halt, 1);
        chk("t6_halt_early", bus.halt, 0);
        idle(); step();
        chk("t6_halt_wait", bus.halt, 0);
        wb(0, 3, 1, 1); step();
        chk("t6_halt_wb_edge", bus.halt, 0);
        idle(); step();
        chk("t6_halt", bus.halt, 1);
        fetch(20, 0, 0, 1, 0, 0, 0, 0, 0); step();
        chk("t6_freeze_halted", last_freeze, 1);
        chk("t6_halt_sticky", bus.halt, 1);
        chk("queue_drained", exp_q.size(), 0);
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
